// File: rtl/adc_tap_cal_ctrl.sv
// rtl/adc_tap_cal_ctrl.sv - per-lane input-delay tap sweep and eye-centre calibration
// Sweeps every tap on each lane, finds the longest passing tap window and loads its centre.
module adc_tap_cal_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int TAP_BITS   = 5,
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_CYC = 64,
  localparam int LANE_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [LANE_W-1:0]     dly_lane,
  output logic [TAP_BITS-1:0]   dly_tap,
  output logic                  dly_load,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] lane_err
);

  localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LEN_W   = TAP_BITS + 1;

  localparam logic [TAP_BITS-1:0] TAP_LAST    = '1;
  localparam logic [LANE_W-1:0]   LANE_LAST   = LANE_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [TAP_BITS-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fail_q, fail_d;
  logic [LEN_W-1:0]      cur_len_q, cur_len_d;
  logic [TAP_BITS-1:0]   cur_start_q, cur_start_d;
  logic [LEN_W-1:0]      best_len_q, best_len_d;
  logic [TAP_BITS-1:0]   best_start_q, best_start_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] lane_err_q, lane_err_d;

  logic [LEN_W-1:0]      pass_len;
  logic [TAP_BITS-1:0]   run_start;
  logic [LEN_W-1:0]      half_len;
  logic [TAP_BITS-1:0]   apply_tap;
  logic                  lane_stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lane_q       <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      fail_q       <= 1'b0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      prev_q       <= '0;
      lane_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      prev_q       <= prev_d;
      lane_err_q   <= lane_err_d;
    end
  end

  // A run that begins on this tap starts here; otherwise it extends the current run.
  always_comb begin
    pass_len   = cur_len_q + LEN_W'(1);
    run_start  = (cur_len_q == '0) ? tap_q : cur_start_q;
    half_len   = (best_len_q - LEN_W'(1)) >> 1;
    apply_tap  = (best_len_q != '0) ? (best_start_q + half_len[TAP_BITS-1:0]) : '0;
    lane_stuck = (din[lane_q] == prev_q[lane_q]);
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    fail_d       = fail_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    prev_d       = din;
    lane_err_d   = lane_err_q;
    dly_load     = 1'b0;
    dly_lane     = '0;
    dly_tap      = '0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_LOAD;
            lane_d       = '0;
            tap_d        = '0;
            cur_len_d    = '0;
            cur_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
            lane_err_d   = '0;
          end
        end
        S_LOAD: begin
          dly_load = 1'b1;
          dly_lane = lane_q;
          dly_tap  = tap_q;
          cnt_d    = '0;
          fail_d   = 1'b0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (lane_stuck) fail_d = 1'b1;
          if (cnt_q == SAMPLE_LAST) begin
            state_d = S_EVAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_EVAL: begin
          if (!fail_q) begin
            cur_len_d   = pass_len;
            cur_start_d = run_start;
            // Strict compare keeps the earliest window on equal lengths.
            if (pass_len > best_len_q) begin
              best_len_d   = pass_len;
              best_start_d = run_start;
            end
          end else begin
            cur_len_d = '0;
          end
          if (tap_q == TAP_LAST) begin
            state_d = S_APPLY;
          end else begin
            tap_d   = tap_q + TAP_BITS'(1);
            state_d = S_LOAD;
          end
        end
        S_APPLY: begin
          dly_load = 1'b1;
          dly_lane = lane_q;
          dly_tap  = apply_tap;
          if (best_len_q == '0) lane_err_d[lane_q] = 1'b1;
          if (lane_q == LANE_LAST) begin
            state_d = S_DONE;
          end else begin
            lane_d       = lane_q + LANE_W'(1);
            tap_d        = '0;
            cur_len_d    = '0;
            cur_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
            state_d      = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign lane_err = lane_err_q;

endmodule

// File: tb/tb_adc_tap_cal_ctrl.sv
// tb/tb_adc_tap_cal_ctrl.sv - directed bench for adc_tap_cal_ctrl with a tap-dependent lane model
module tb_adc_tap_cal_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] din = '0;
  logic [0:0] dly_lane;
  logic [2:0] dly_tap;
  logic       dly_load;
  logic       busy;
  logic       done;
  logic [1:0] lane_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Lane model: a lane toggles every cycle only while its loaded tap is in its pass mask.
  logic [7:0] mask [2];
  logic [2:0] cur_tap [2];
  logic [2:0] apply_tap [2];
  int         ld_cnt [2];
  int         total_loads;
  logic       tog = 1'b0;

  adc_tap_cal_ctrl #(
    .DATA_WIDTH (2),
    .TAP_BITS   (3),
    .SETTLE_CYC (2),
    .SAMPLE_CYC (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .din      (din),
    .dly_lane (dly_lane),
    .dly_tap  (dly_tap),
    .dly_load (dly_load),
    .busy     (busy),
    .done     (done),
    .lane_err (lane_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int l;
    #1;
    if (dly_load) begin
      l = int'(dly_lane);
      total_loads++;
      if (ld_cnt[l] < 8) begin
        n_assert++;
        if (dly_tap !== 3'(ld_cnt[l])) begin
          n_fail++;
          $display("FAIL sweep_tap lane %0d: got %0d, expected %0d", l, dly_tap, ld_cnt[l]);
        end
      end else if (ld_cnt[l] == 8) begin
        apply_tap[l] = dly_tap;
      end
      ld_cnt[l]++;
      cur_tap[l] = dly_tap;
    end
    tog = ~tog;
    for (int i = 0; i < 2; i++) din[i] = mask[i][cur_tap[i]] ? tog : 1'b0;
  end

  task automatic clear_model(input logic [7:0] m0, input logic [7:0] m1);
    mask[0] = m0;
    mask[1] = m1;
    for (int i = 0; i < 2; i++) begin
      cur_tap[i]   = '0;
      apply_tap[i] = '0;
      ld_cnt[i]    = 0;
    end
    total_loads = 0;
  endtask

  task automatic pulse_start(input logic [7:0] m0, input logic [7:0] m1);
    clear_model(m0, m1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_lane1_load(input string name);
    int i;
    for (i = 0; i < 300 && ld_cnt[1] == 0; i++) begin
      @(negedge clk);
      #2;
    end
    n_assert++;
    if (ld_cnt[1] == 0) begin
      n_fail++;
      $display("FAIL %s lane1_load: got no load within %0d cycles, expected one", name, i);
    end
  endtask

  task automatic check_run(input string name, input logic [7:0] m0, input logic [7:0] m1,
                           input bit hold, input logic [2:0] exp0, input logic [2:0] exp1,
                           input logic [1:0] exp_err);
    int   n;
    logic prev_busy;
    clear_model(m0, m1);
    prev_busy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n == 1)          start = 1'b0;
      if (hold && n == 10)  start = 1'b1;
      if (hold && n == 100) start = 1'b0;
      if (done) break;
      prev_busy = busy;
    end
    n_assert++;
    if (n !== 131) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d, expected 131", name, n);
    end
    n_assert++;
    if ({prev_busy, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s busy_fall: got prev=%0b now=%0b, expected prev=1 now=0", name, prev_busy, busy);
    end
    n_assert++;
    if (apply_tap[0] !== exp0) begin
      n_fail++;
      $display("FAIL %s apply_lane0: got %0d, expected %0d", name, apply_tap[0], exp0);
    end
    n_assert++;
    if (apply_tap[1] !== exp1) begin
      n_fail++;
      $display("FAIL %s apply_lane1: got %0d, expected %0d", name, apply_tap[1], exp1);
    end
    n_assert++;
    if (lane_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s lane_err: got %b, expected %b", name, lane_err, exp_err);
    end
    n_assert++;
    if (ld_cnt[0] != 9 || ld_cnt[1] != 9) begin
      n_fail++;
      $display("FAIL %s load_count: got %0d/%0d, expected 9/9", name, ld_cnt[0], ld_cnt[1]);
    end
    repeat (3) @(negedge clk);
    n_assert++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s done_held: got done=%0b busy=%0b, expected done=1 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    clear_model(8'h00, 8'h00);
    #1 rst_n = 1'b0;
    #2;
    n_assert++;
    if ({dly_lane, dly_tap, dly_load, busy, done, lane_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {dly_lane, dly_tap, dly_load, busy, done, lane_err});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_assert++;
    if ({busy, done, dly_load} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b done=%0b load=%0b, expected 0", busy, done, dly_load);
    end
  endtask

  task automatic test_window_tie;
    check_run("window_tie", 8'h3C, 8'h66, 1'b0, 3'd3, 3'd1, 2'b00);
  endtask

  task automatic test_extremes;
    check_run("extremes", 8'h00, 8'hFF, 1'b0, 3'd0, 3'd3, 2'b01);
  endtask

  task automatic test_tap_limit;
    check_run("tap_limit", 8'hE0, 8'h01, 1'b0, 3'd6, 3'd0, 2'b00);
  endtask

  task automatic test_start_busy;
    check_run("start_busy", 8'h18, 8'h3F, 1'b1, 3'd3, 3'd2, 2'b00);
  endtask

  task automatic test_abort;
    int saved;
    pulse_start(8'h00, 8'hFF);
    wait_lane1_load("abort");
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if ({busy, done, dly_load} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%0b done=%0b load=%0b, expected 0", busy, done, dly_load);
    end
    n_assert++;
    if (lane_err !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_lane_err: got %b, expected 01", lane_err);
    end
    @(negedge clk);
    abort = 1'b0;
    saved = total_loads;
    repeat (30) @(negedge clk);
    n_assert++;
    if (total_loads != saved || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got loads=%0d busy=%0b, expected loads=%0d busy=0", total_loads, busy, saved);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if ({busy, lane_err} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_priority: got busy=%0b lane_err=%b, expected busy=0 lane_err=01", busy, lane_err);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid;
    int saved;
    pulse_start(8'h00, 8'hFF);
    wait_lane1_load("reset_mid");
    n_assert++;
    if (lane_err !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_pre_err: got %b, expected 01", lane_err);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_assert++;
    if ({dly_lane, dly_tap, dly_load, busy, done, lane_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b, expected all zero",
               {dly_lane, dly_tap, dly_load, busy, done, lane_err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saved = total_loads;
    repeat (20) @(negedge clk);
    n_assert++;
    if (total_loads != saved || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_resume: got loads=%0d busy=%0b, expected loads=%0d busy=0", total_loads, busy, saved);
    end
    check_run("after_reset", 8'h3C, 8'h66, 1'b0, 3'd3, 3'd1, 2'b00);
  endtask

  initial begin
    test_reset();
    test_window_tie();
    test_extremes();
    test_tap_limit();
    test_start_busy();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
